// File: rtl/shift_req_sched_pkg.sv
// Shared types for the shift request scheduler. ID_W is sized for the largest
// supported requester count so tag_t stays a fixed type across configurations.
package shift_req_sched_pkg;

  localparam int MAX_REQ = 16;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W = id_width(MAX_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} sched_state_e;

endpackage

// File: rtl/shift_req_sched_rr_arbiter.sv
// Rotating-priority one-hot picker: search starts at the pointer and wraps;
// the pointer advances to winner+1 on a grant and holds otherwise.
module rr_arbiter
  import shift_req_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_any_o,
  output logic [ID_W-1:0]    gnt_id_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  // First pass covers indices at/above the pointer, second pass the wrap.
  always_comb begin
    gnt_o     = '0;
    gnt_any_o = 1'b0;
    gnt_id_o  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en_i && !gnt_any_o && req_i[i] && (ID_W'(i) >= ptr_q)) begin
        gnt_any_o = 1'b1;
        gnt_o[i]  = 1'b1;
        gnt_id_o  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en_i && !gnt_any_o && req_i[i] && (ID_W'(i) < ptr_q)) begin
        gnt_any_o = 1'b1;
        gnt_o[i]  = 1'b1;
        gnt_id_o  = ID_W'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = (gnt_id_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shift_req_sched.sv
// Round-robin front end for a shared LATENCY-deep barrel shifter, with tag
// steering and a drain handshake. Define SHIFT_REQ_SCHED_STATS_EN for grant counters.
module shift_req_sched
  import shift_req_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SIZE       = 32,
  parameter int SHIFT_SIZE = 8,
  parameter int LATENCY    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*SIZE-1:0]      req_data,
  input  logic [NUM_REQ*SHIFT_SIZE-1:0] req_shift,
  output logic [SIZE-1:0]              sh_din,
  output logic [SHIFT_SIZE-1:0]        sh_shift,
  input  logic [SIZE-1:0]              sh_dout,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [SIZE-1:0]              rsp_data,
  input  logic                         drain_req,
  output logic                         drained,
  output logic                         busy
`ifdef SHIFT_REQ_SCHED_STATS_EN
  ,
  input  logic                         stat_clr,
  output logic [NUM_REQ*16-1:0]        stat_cnt
`endif
);

  sched_state_e state_q, state_d;
  logic [NUM_REQ-1:0]    gnt;
  logic                  gnt_any;
  logic [ID_W-1:0]       gnt_id;
  logic                  gnt_en;
  logic [SIZE-1:0]       sh_din_q, sh_din_d;
  logic [SHIFT_SIZE-1:0] sh_shift_q, sh_shift_d;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [SIZE-1:0]       rsp_data_q;
  tag_t                  tag_q [0:LATENCY];

  // Gating with rst_n keeps req_ready low while reset is asserted.
  assign gnt_en = (state_q == RUN) && rst_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (gnt_en),
    .req_i    (req_valid),
    .gnt_o    (gnt),
    .gnt_any_o(gnt_any),
    .gnt_id_o (gnt_id)
  );

  assign req_ready = gnt;

  always_comb begin
    sh_din_d   = sh_din_q;
    sh_shift_d = sh_shift_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sh_din_d   = req_data[i*SIZE +: SIZE];
        sh_shift_d = req_shift[i*SHIFT_SIZE +: SHIFT_SIZE];
      end
    end
  end

  // Stage 0 of the tag pipe runs alongside the operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_din_q   <= '0;
      sh_shift_q <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
    end else begin
      sh_din_q   <= sh_din_d;
      sh_shift_q <= sh_shift_d;
      tag_q[0]   <= '{valid: gnt_any, id: gnt_id};
      for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else if (tag_q[LATENCY].valid) begin
      rsp_valid_q <= NUM_REQ'(1) << tag_q[LATENCY].id;
      rsp_data_q  <= sh_dout;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= LATENCY; i++) busy = busy | tag_q[i].valid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (!drain_req) state_d = RUN;
               else if (!busy) state_d = IDLE;
      IDLE:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign sh_din    = sh_din_q;
  assign sh_shift  = sh_shift_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign drained   = (state_q == IDLE);

`ifdef SHIFT_REQ_SCHED_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  // Clear has priority over a same-cycle grant increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr)                            cnt_q[i] <= '0;
        else if (gnt[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_shift_req_sched.sv
// Directed bench for shift_req_sched with a 4-stage left-shift stub shifter.
module tb_shift_req_sched;

  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int SW  = 8;
  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_data;
  logic [NR*SW-1:0]  req_shift;
  logic [W-1:0]      sh_din;
  logic [SW-1:0]     sh_shift;
  logic [W-1:0]      sh_dout;
  logic [NR-1:0]     rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              drain_req;
  logic              drained;
  logic              busy;
`ifdef SHIFT_REQ_SCHED_STATS_EN
  logic              stat_clr;
  logic [NR*16-1:0]  stat_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_req_sched #(.NUM_REQ(NR), .SIZE(W), .SHIFT_SIZE(SW), .LATENCY(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_shift(req_shift),
    .sh_din   (sh_din),
    .sh_shift (sh_shift),
    .sh_dout  (sh_dout),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .drain_req(drain_req),
    .drained  (drained),
    .busy     (busy)
`ifdef SHIFT_REQ_SCHED_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt)
`endif
  );

  logic [W-1:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= sh_din << sh_shift;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sh_dout = pipe[LAT-1];

  typedef struct {
    logic [NR-1:0] rv;
    logic          drn;
    logic [NR-1:0] rdy;
    logic [NR-1:0] rsp;
    logic          bsy;
    logic          drd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [NR-1:0] rv, input logic drn, input logic [NR-1:0] rdy,
                     input logic [NR-1:0] rsp, input logic bsy, input logic drd);
    vec_t v;
    v.rv = rv; v.drn = drn; v.rdy = rdy; v.rsp = rsp; v.bsy = bsy; v.drd = drd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-computed shifter results: F1<<4, 80000003<<1, A5A5A5A5<<0, 1<<31.
  function automatic logic [W-1:0] exp_res(input logic [NR-1:0] oh);
    case (oh)
      4'b0001: return 32'h0000_0F10;
      4'b0010: return 32'h0000_0006;
      4'b0100: return 32'hA5A5_A5A5;
      4'b1000: return 32'h8000_0000;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  logic [W-1:0] last_data;

  initial begin
    req_data  = {32'h0000_0001, 32'hA5A5_A5A5, 32'h8000_0003, 32'h0000_00F1};
    req_shift = {8'd31, 8'd0, 8'd1, 8'd4};

    //   rv       drn   rdy      rsp      bsy   drd
    add(4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0); // c0
    add(4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0);
    add(4'b1010, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0); // pointer=2
    add(4'b1010, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0);
    add(4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0);
    add(4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0); // c5
    add(4'b1111, 1'b0, 4'b0010, 4'b0001, 1'b1, 1'b0);
    add(4'b1111, 1'b0, 4'b0100, 4'b0010, 1'b1, 1'b0);
    add(4'b1111, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0);
    add(4'b1111, 1'b0, 4'b0001, 4'b0010, 1'b1, 1'b0);
    add(4'b1111, 1'b0, 4'b0010, 4'b1000, 1'b1, 1'b0); // c10
    add(4'b1111, 1'b0, 4'b0100, 4'b0001, 1'b1, 1'b0);
    add(4'b1111, 1'b0, 4'b1000, 4'b0010, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0); // c15
    add(4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0);
    add(4'b0111, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);
    add(4'b0111, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0); // c20
    add(4'b0111, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0); // drain rises with a grant
    add(4'b0111, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(4'b0111, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(4'b0111, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(4'b0111, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0); // c25
    add(4'b0111, 1'b1, 4'b0000, 4'b0010, 1'b1, 1'b0);
    add(4'b0111, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0);
    add(4'b0111, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(4'b0111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(4'b0111, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0); // c30
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0); // c35
    add(4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    drain_req = 1'b0;
`ifdef SHIFT_REQ_SCHED_STATS_EN
    stat_clr  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("reset req_ready", req_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data",  rsp_data,  0);
    chk("reset sh_din",    sh_din,    0);
    chk("reset sh_shift",  sh_shift,  0);
    chk("reset busy",      busy,      0);
    chk("reset drained",   drained,   0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;

    last_data = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req_valid = vecs[i].rv;
      drain_req = vecs[i].drn;
      #1;
      if (vecs[i].rsp != '0) last_data = exp_res(vecs[i].rsp);
      chk($sformatf("row%0d req_ready", i), req_ready, vecs[i].rdy);
      chk($sformatf("row%0d rsp_valid", i), rsp_valid, vecs[i].rsp);
      chk($sformatf("row%0d rsp_data", i),  rsp_data,  last_data);
      chk($sformatf("row%0d busy", i),      busy,      vecs[i].bsy);
      chk($sformatf("row%0d drained", i),   drained,   vecs[i].drd);
    end

    // Fill the pipe, then reset asynchronously mid-cycle.
    req_valid = 4'b1111;
    repeat (5) @(negedge clk);
    #1;
    chk("prereset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async req_ready", req_ready, 0);
    chk("async rsp_valid", rsp_valid, 0);
    chk("async rsp_data",  rsp_data,  0);
    chk("async sh_din",    sh_din,    0);
    chk("async sh_shift",  sh_shift,  0);
    chk("async busy",      busy,      0);
    chk("async drained",   drained,   0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postreset%0d rsp_valid", i), rsp_valid, 0);
    end
    req_valid = 4'b1111;
    #1;
    chk("postreset pointer grant", req_ready, 4'b0001);

`ifdef SHIFT_REQ_SCHED_STATS_EN
    @(negedge clk);
    req_valid = '0;
    stat_clr  = 1'b1;
    @(negedge clk);
    stat_clr  = 1'b0;
    #1;
    chk("stat cleared", stat_cnt[2*16 +: 16], 0);
    req_valid = 4'b0100;
    for (int n = 0; n < 70000; n++) @(negedge clk);
    #1;
    chk("stat saturated", stat_cnt[2*16 +: 16], 16'hFFFF);
    chk("stat other req", stat_cnt[0 +: 16], 0);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    chk("stat clr wins", stat_cnt[2*16 +: 16], 0);
    @(negedge clk);
    #1;
    chk("stat recount", stat_cnt[2*16 +: 16], 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_req_sched.md
Name: shift_req_sched

Overview:
- Shares one pipelined barrel shifter among NUM_REQ requesters.
- Round-robin arbiter grants at most one request per cycle and drives the shifter operand/amount ports.
- Carries a requester-ID tag down a LATENCY-deep shadow pipeline and steers each shifter result back to its owner.
- Provides a drain/quiesce handshake so software can reconfigure downstream logic with the shifter empty.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- SIZE, 32, data width of the shifter.
- SHIFT_SIZE, 8, width of the shift-amount field.
- LATENCY, 4, fixed cycles from shifter input sample to shifter output valid (1..16).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when valid&ready.
- req_data  in  NUM_REQ*SIZE  packed operands; requester i uses bits [i*SIZE +: SIZE].
- req_shift  in  NUM_REQ*SHIFT_SIZE  packed shift amounts.
- sh_din  out  SIZE  to shifter din.
- sh_shift  out  SHIFT_SIZE  to shifter shift.
- sh_dout  in  SIZE  from shifter dout.
- rsp_valid  out  NUM_REQ  one-hot result strobe, 1 cycle.
- rsp_data  out  SIZE  result, registered.
- drain_req  in  1  level; stop granting and empty the pipeline.
- drained  out  1  high while the pipeline is empty and drain_req is held.
- busy  out  1  any tag in flight.

Behaviour:
- Reset (async assert, sync deassert) drives req_ready=0, rsp_valid=0, rsp_data=0, sh_din=0, sh_shift=0, drained=0, busy=0, RR pointer=0, all tag-pipe valids=0, FSM=RUN.
- Arbitration is combinational from req_valid and the RR pointer. Search starts at the pointer and picks the first valid index with wraparound. req_ready is one-hot on the winner and 0 otherwise, so it never asserts without valid. On a grant, the pointer moves to winner+1 mod NUM_REQ; with no grant it holds.
- On a grant, sh_din and sh_shift register the winner's operands on the same edge. The shifter samples them on the next edge. With no grant, sh_din and sh_shift hold their values.
- Tag pipe is LATENCY+1 stages of {valid, id[$clog2(NUM_REQ)-1:0]}, stage 0 loaded with the grant. When the last stage is valid, rsp_data<=sh_dout and rsp_valid<=onehot(id); otherwise rsp_valid<=0 and rsp_data holds.
- Total request-to-rsp_valid latency is LATENCY+2 cycles.
- There is no back-pressure on responses: rsp_valid is unconditional, and owners must sink results.
- Throughput is one grant per cycle. A single requester held valid is granted every cycle.
- FSM states:
  - RUN: grants enabled. drain_req=1 -> DRAIN.
  - DRAIN: no grants; req_ready=0. If the tag pipe is empty and the grant register is empty -> IDLE.
  - IDLE: drained=1, no grants. drain_req=0 -> RUN on the next cycle.
  - drain_req dropping while in DRAIN -> RUN without waiting.
- A grant and drain_req rising in the same cycle: the grant on that edge completes, and in-flight work always completes.
- busy = OR of tag-pipe valids and the grant register.
- Reset mid-operation discards all in-flight tags, with no rsp_valid for them.

Optional Feature:
- SHIFT_REQ_SCHED_STATS_EN defined: adds per-requester 16-bit saturating grant counters.
  - Counters are read via output stat_cnt (NUM_REQ*16) and cleared by input stat_clr (1-cycle pulse).
  - stat_clr wins over a simultaneous grant increment; counters reset to 0.
- Undefined: no counters and no stat ports.

Decomposition:
- Package shift_req_sched_pkg holds:
  - localparam ID_W function (clog2 of NUM_REQ, min 1).
  - typedef tag_t {logic valid; logic [ID_W-1:0] id;}.
  - FSM enum sched_state_e {RUN, DRAIN, IDLE}.
- One sub-module, rr_arbiter: NUM_REQ-wide rotating-priority one-hot picker with pointer update. It is reusable elsewhere.

Test Plan:
1. Single requester 0, data=32'h0000_00F1, shift=4, stub shifter=left shift of LATENCY=4 -> rsp_valid=4'b0001 exactly 6 cycles after the grant, rsp_data=32'h0000_0F10.
2. All 4 requesters valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3. Responses return in the same order with matching ids, with no gaps.
3. Requesters 1 and 3 valid, pointer=2 -> grant 3 first, then 1. Pointer is 0 after the grant to 3 and 2 after the grant to 1.
4. drain_req raised with 3 tags in flight -> req_ready=0 immediately. All 3 responses delivered, drained=1 one cycle after the last stage empties. Dropping drain_req gives the first grant next cycle.
5. rst_n pulsed low with pipeline full -> all outputs 0 asynchronously, no rsp_valid after release, pointer=0.
6. With SHIFT_REQ_SCHED_STATS_EN: 70000 grants to requester 2 -> stat_cnt[2]=16'hFFFF. stat_clr pulse -> 0.
